// File: rtl/scan_chain_ctrl_pkg.sv
// rtl/scan_chain_ctrl_pkg.sv - shared types and helpers for the scan chain controller
package scan_chain_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_IN,
      ST_CAPTURE,
      ST_SHIFT_OUT,
      ST_REPORT
   } state_e;

   function automatic int cnt_width(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/scan_chain_ctrl_shift_cnt.sv
// rtl/scan_chain_ctrl_shift_cnt.sv - saturating shift counter with terminal-count flag
module scan_shift_cnt #(
   parameter int LIMIT = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rn,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   assign tc  = (cnt_q == CNT_W'(LIMIT - 1));
   assign cnt = cnt_q;

   // Holding at LIMIT-1 rather than wrapping keeps tc stable if the FSM lingers.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load, capture and unload one scan chain, then compare the response
module scan_chain_ctrl
   import scan_chain_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN = 16,
   parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [CHAIN_LEN-1:0] PAT_IN,
   input  logic [CHAIN_LEN-1:0] EXP_IN,
   input  logic                 SO,
   output logic                 SE,
   output logic                 SI,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 PASS,
   output logic [CHAIN_LEN-1:0] CAP_DATA
);

   state_e               state_d, state_q;
   logic                 se_d, se_q;
   logic                 si_d, si_q;
   logic                 busy_d, busy_q;
   logic                 done_d, done_q;
   logic                 pass_d, pass_q;
   logic [CHAIN_LEN-1:0] cap_d, cap_q;
   logic [CHAIN_LEN-1:0] pat_d, pat_q;
   logic [CHAIN_LEN-1:0] exp_d, exp_q;

   logic [CNT_W-1:0]     cnt;
   logic                 cnt_tc;
   logic                 cnt_clr;
   logic                 cnt_en;

   assign cnt_clr = (state_d != state_q);
   assign cnt_en  = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);

   scan_shift_cnt #(
      .LIMIT (CHAIN_LEN),
      .CNT_W (CNT_W)
   ) u_shift_cnt (
      .clk (CLK),
      .rn  (RN),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      se_d    = se_q;
      si_d    = si_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      cap_d   = cap_q;
      pat_d   = pat_q;
      exp_d   = exp_q;

      case (state_q)
         ST_IDLE: begin
            se_d   = 1'b0;
            si_d   = 1'b0;
            busy_d = 1'b0;
            if (START) begin
               // pat_q keeps the bits still to be sent, MSB first
               pat_d   = {PAT_IN[CHAIN_LEN-2:0], 1'b0};
               exp_d   = EXP_IN;
               cap_d   = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               se_d    = 1'b1;
               si_d    = PAT_IN[CHAIN_LEN-1];
               state_d = ST_SHIFT_IN;
            end
         end
         ST_SHIFT_IN: begin
            if (cnt_tc) begin
               se_d    = 1'b0;
               si_d    = 1'b0;
               state_d = ST_CAPTURE;
            end else begin
               si_d  = pat_q[CHAIN_LEN-1];
               pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
            end
         end
         ST_CAPTURE: begin
            se_d    = 1'b1;
            si_d    = 1'b0;
            state_d = ST_SHIFT_OUT;
         end
         ST_SHIFT_OUT: begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
               if (cnt == CNT_W'(CHAIN_LEN - 1 - i)) begin
                  cap_d[i] = SO;
               end
            end
            if (cnt_tc) begin
               se_d    = 1'b0;
               done_d  = 1'b1;
               pass_d  = (cap_d == exp_q);
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            se_d    = 1'b0;
            si_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (ABORT && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         se_d    = 1'b0;
         si_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         cap_d   = cap_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         se_q    <= 1'b0;
         si_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         cap_q   <= '0;
         pat_q   <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         se_q    <= se_d;
         si_q    <= si_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         cap_q   <= cap_d;
         pat_q   <= pat_d;
         exp_q   <= exp_d;
      end
   end

   assign SE       = se_q;
   assign SI       = si_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign PASS     = pass_q;
   assign CAP_DATA = cap_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench driving a 4-flop scan chain model
module tb_scan_chain_ctrl;

   logic       clk = 1'b0;
   logic       RN, START, ABORT;
   logic [3:0] PAT_IN, EXP_IN;
   logic       SO, SE, SI, BUSY, DONE, PASS;
   logic [3:0] CAP_DATA;

   logic [3:0] chain = 4'b0000;
   logic [3:0] d_val;
   logic       hold_mode;

   int         n_checks = 0;
   int         n_pass   = 0;

   logic [9:0] se_tr;
   logic [3:0] si_tr;
   logic [3:0] chain_cap;
   int         done_cyc;
   int         n_done;
   logic       busy_c1, busy_c11;
   int         done_at[4];

   always #5 clk = ~clk;

   scan_chain_ctrl #(.CHAIN_LEN(4)) dut (
      .CLK      (clk),
      .RN       (RN),
      .START    (START),
      .ABORT    (ABORT),
      .PAT_IN   (PAT_IN),
      .EXP_IN   (EXP_IN),
      .SO       (SO),
      .SE       (SE),
      .SI       (SI),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .PASS     (PASS),
      .CAP_DATA (CAP_DATA)
   );

   assign SO = chain[3];

   always @(posedge clk) begin
      if (SE) chain <= {chain[2:0], SI};
      else    chain <= hold_mode ? chain : d_val;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called on a negedge; cycle c of the trace is the c-th negedge after the accepting edge.
   task automatic run_seq(input logic [3:0] pat, input logic [3:0] exp);
      START    = 1'b1;
      PAT_IN   = pat;
      EXP_IN   = exp;
      n_done   = 0;
      done_cyc = -1;
      se_tr    = '0;
      si_tr    = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin
            START  = 1'b0;
            PAT_IN = ~pat;
            EXP_IN = ~exp;
            busy_c1 = BUSY;
         end
         if (c <= 10) se_tr[c-1] = SE;
         if (c <= 4)  si_tr[c-1] = SI;
         if (c == 5)  chain_cap = chain;
         if (c == 11) busy_c11 = BUSY;
         if (DONE) begin
            n_done++;
            done_cyc = c;
         end
      end
   endtask

   initial begin
      RN = 1'b0; START = 1'b0; ABORT = 1'b0;
      PAT_IN = '0; EXP_IN = '0; d_val = '0; hold_mode = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", 32'({SE, SI, BUSY, DONE, PASS}), 32'h0);
      check("reset_cap", 32'(CAP_DATA), 32'h0);
      RN = 1'b1;
      @(negedge clk);

      d_val = 4'b0110;
      run_seq(4'b1011, 4'b0110);
      check("a_se_trace", 32'(se_tr), 32'(10'b0111101111));
      check("a_si_trace", 32'(si_tr), 32'(4'b1101));
      check("a_chain_loaded", 32'(chain_cap), 32'(4'b1011));
      check("a_done_cyc", 32'(done_cyc), 32'd10);
      check("a_done_pulses", 32'(n_done), 32'd1);
      check("a_busy_c1", 32'(busy_c1), 32'd1);
      check("a_busy_c11", 32'(busy_c11), 32'd0);
      check("a_cap", 32'(CAP_DATA), 32'(4'b0110));
      check("a_pass", 32'(PASS), 32'd1);

      run_seq(4'b1011, 4'b0111);
      check("b_done_cyc", 32'(done_cyc), 32'd10);
      check("b_cap", 32'(CAP_DATA), 32'(4'b0110));
      check("b_pass", 32'(PASS), 32'd0);

      hold_mode = 1'b1;
      run_seq(4'b1001, 4'b1001);
      check("hold_si_trace", 32'(si_tr), 32'(4'b1001));
      check("hold_cap", 32'(CAP_DATA), 32'(4'b1001));
      check("hold_pass", 32'(PASS), 32'd1);
      hold_mode = 1'b0;

      ABORT = 1'b1;
      repeat (2) @(negedge clk);
      ABORT = 1'b0;
      check("idle_abort_pass", 32'(PASS), 32'd1);
      check("idle_abort_cap", 32'(CAP_DATA), 32'(4'b1001));
      check("idle_abort_busy", 32'(BUSY), 32'd0);

      START = 1'b1; PAT_IN = 4'b1011; EXP_IN = 4'b0110;
      n_done = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) START = 1'b0;
         if (c == 8) ABORT = 1'b1;
         if (c == 9) begin
            check("abort_outs", 32'({SE, SI, BUSY, PASS}), 32'h0);
            ABORT = 1'b0;
         end
         if (DONE) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);

      n_done = 0;
      START = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (DONE) begin
            if (n_done < 4) done_at[n_done] = c;
            n_done++;
         end
      end
      START = 1'b0;
      check("b2b_done_count", 32'(n_done), 32'd3);
      if (n_done >= 3) begin
         check("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd11);
         check("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd11);
      end
      repeat (12) @(negedge clk);

      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
      @(negedge clk);
      check("mid_shift_busy", 32'(BUSY), 32'd1);
      RN = 1'b0;
      @(negedge clk);
      check("rst_mid_outs", 32'({SE, SI, BUSY, DONE, PASS}), 32'h0);
      check("rst_mid_cap", 32'(CAP_DATA), 32'h0);
      RN = 1'b1;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
